// File: rtl/cc40_pkg.sv
// cc40_pkg: shared types and constants for the CC-40 command scheduler.
//   state_e          - scheduler FSM states
//   CC40_HDR/PAD     - fixed header and pad bytes of a CC-40 frame
//   CC40_FRAME_LEN   - bytes per frame
//   cc40_frame_byte  - byte idx of the frame {HDR, cmd, PAD, arg}
package cc40_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [7:0]  CC40_HDR       = 8'd50;
    localparam logic [7:0]  CC40_PAD       = 8'd0;
    localparam int unsigned CC40_FRAME_LEN = 4;

    function automatic logic [7:0] cc40_frame_byte(input logic [1:0] idx,
                                                   input logic [7:0] cmd,
                                                   input logic [7:0] arg);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CC40_HDR;
            2'd1:    b = cmd;
            2'd2:    b = CC40_PAD;
            default: b = arg;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cc40_rr_arbiter.sv
// cc40_rr_arbiter: combinational round-robin pick among pending requesters.
//   pend  in  NREQ        pending flags
//   ptr   in  clog2(NREQ) highest-priority index for this pick
//   en    in  1           enable; grant is all-zero when low
//   grant out NREQ        one-hot winner (zero when nothing pending or disabled)
//   idx   out clog2(NREQ) binary index of the winner (0 when no grant)
module cc40_rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         pend,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned PW = $clog2(NREQ);

    logic          found;
    int unsigned   cand;
    logic [PW-1:0] cand_idx;

    // Walk upward from ptr with wrap; the first pending slot wins.
    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand     = (32'(ptr) + off) % NREQ;
            cand_idx = PW'(cand);
            if (en && !found && pend[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/cc40_cmd_scheduler.sv
// cc40_cmd_scheduler: shares the CC-40 commutator link between NREQ command sources.
// Each source's strobed command is latched as pending; a round-robin arbiter picks one,
// its 4-byte frame {50, cmd, 0, arg} is sent over a valid/ready byte link, and a fixed
// idle gap follows every frame, whether it completed or was aborted on a stall timeout.
//   clk, rst      clock, asynchronous active-high reset
//   req_i         per-source one-cycle request strobes
//   cmd_i, arg_i  per-source command/argument bytes, slice i = [8i+7:8i]
//   tx_valid, tx_ready, tx_data, tx_last   byte link to the CC-40 transmitter
//   grant_o       one-hot owner of the frame being sent (0 outside SEND)
//   busy          scheduler not idle
//   abort_o       one-cycle pulse when a frame is dropped on timeout
//   overrun_cnt   saturating count of requests that overwrote a pending one
module cc40_cmd_scheduler
    import cc40_pkg::*;
#(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned GAP_CYCLES     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] cmd_i,
    input  logic [8*NREQ-1:0] arg_i,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_last,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy,
    output logic              abort_o,
    output logic [7:0]        overrun_cnt
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0]    LAST_IDX = 2'(CC40_FRAME_LEN - 1);
    localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    // Request capture
    logic [NREQ-1:0] pend_q, pend_d;
    logic [7:0]      cmd_q [NREQ];
    logic [7:0]      arg_q [NREQ];
    logic [3:0]      n_ovr;
    logic [8:0]      ovr_sum;
    logic [7:0]      ovr_d;

    // Arbitration / framing
    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [1:0]      idx_q;
    logic [7:0]      fcmd_q, farg_q;
    logic [TW-1:0]   to_q;
    logic [GW-1:0]   gap_q;

    logic            arb_en;
    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   arb_idx;

    assign arb_en = (state_q == IDLE);

    cc40_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .pend  (pend_q),
        .ptr   (ptr_q),
        .en    (arb_en),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // A strobe landing on the same clock as its grant re-arms pend and is not an overrun.
    always_comb begin
        pend_d = (pend_q & ~arb_grant) | req_i;
        n_ovr  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_i[i] && pend_q[i] && !arb_grant[i]) begin
                n_ovr = n_ovr + 4'd1;
            end
        end
        ovr_sum = {1'b0, overrun_cnt} + 9'(n_ovr);
        ovr_d   = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            overrun_cnt <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cmd_q[i] <= '0;
                arg_q[i] <= '0;
            end
        end else begin
            pend_q      <= pend_d;
            overrun_cnt <= ovr_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_i[i]) begin
                    cmd_q[i] <= cmd_i[8*i +: 8];
                    arg_q[i] <= arg_i[8*i +: 8];
                end
            end
        end
    end

    // Scheduler FSM with registered link outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            fcmd_q   <= '0;
            farg_q   <= '0;
            to_q     <= '0;
            gap_q    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
            grant_o  <= '0;
            busy     <= 1'b0;
            abort_o  <= 1'b0;
        end else begin
            abort_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|arb_grant) begin
                        state_q  <= SEND;
                        fcmd_q   <= cmd_q[arb_idx];
                        farg_q   <= arg_q[arb_idx];
                        ptr_q    <= (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
                        idx_q    <= '0;
                        to_q     <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= CC40_HDR;
                        tx_last  <= 1'b0;
                        grant_o  <= arb_grant;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        to_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q  <= GAP;
                            gap_q    <= GAP_LOAD;
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            tx_last  <= 1'b0;
                            grant_o  <= '0;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            tx_data <= cc40_frame_byte(idx_q + 2'd1, fcmd_q, farg_q);
                            tx_last <= (idx_q + 2'd1 == LAST_IDX);
                        end
                    end else if (to_q == TO_LIMIT) begin
                        // This stalled clock is number TIMEOUT_CYCLES: drop the frame.
                        abort_o  <= 1'b1;
                        state_q  <= GAP;
                        gap_q    <= GAP_LOAD;
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        tx_last  <= 1'b0;
                        grant_o  <= '0;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                GAP: begin
                    gap_q <= gap_q - 1'b1;
                    if (gap_q == GW'(1)) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc40_cmd_scheduler.sv
// Self-checking bench for cc40_cmd_scheduler: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_cc40_cmd_scheduler;

    localparam int NREQ  = 2;
    localparam int GAP_N = 20;
    localparam int TMO   = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] cmd;
    logic [8*NREQ-1:0] arg;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              tx_last;
    logic [NREQ-1:0]   grant_o;
    logic              busy;
    logic              abort_o;
    logic [7:0]        overrun_cnt;

    cc40_cmd_scheduler #(
        .NREQ           (NREQ),
        .GAP_CYCLES     (GAP_N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .cmd_i       (cmd),
        .arg_i       (arg),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .grant_o     (grant_o),
        .busy        (busy),
        .abort_o     (abort_o),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending table plus "which frame byte is on the wire" and
    // "gap clocks left"; outputs are derived from those, not from a state register.
    bit m_pend [NREQ];
    int m_cmd  [NREQ];
    int m_arg  [NREQ];
    int m_frame[4];
    int m_ptr, m_ovr, m_pos, m_stall, m_gap, m_owner;
    bit m_abort;

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_pend[i] = 0;
            m_cmd[i]  = 0;
            m_arg[i]  = 0;
        end
        m_ptr = 0; m_ovr = 0; m_pos = -1; m_stall = 0; m_gap = 0; m_owner = 0; m_abort = 0;
    endtask

    task automatic model_step();
        int w;
        w       = -1;
        m_abort = 0;
        if (m_pos >= 0) begin
            if (tx_ready) begin
                m_stall = 0;
                if (m_pos == 3) begin
                    m_pos = -1;
                    m_gap = GAP_N;
                end else begin
                    m_pos++;
                end
            end else begin
                m_stall++;
                if (m_stall == TMO) begin
                    m_abort = 1;
                    m_pos   = -1;
                    m_gap   = GAP_N;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (w < 0 && m_pend[c]) w = c;
            end
            if (w >= 0) begin
                m_frame    = '{50, m_cmd[w], 0, m_arg[w]};
                m_pend[w]  = 0;
                m_ptr      = (w + 1) % NREQ;
                m_pos      = 0;
                m_stall    = 0;
                m_owner    = w;
            end
        end
        // Pending flag of the winner is already cleared, so a coinciding strobe is no overrun.
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (m_pend[i] && m_ovr < 255) m_ovr++;
                m_pend[i] = 1;
                m_cmd[i]  = int'(cmd[8*i +: 8]);
                m_arg[i]  = int'(arg[8*i +: 8]);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        check_eq("tx_valid", 32'(tx_valid), 32'(m_pos >= 0));
        if (m_pos >= 0) begin
            check_eq("tx_data", 32'(tx_data), m_frame[m_pos]);
            check_eq("tx_last", 32'(tx_last), 32'(m_pos == 3));
        end
        check_eq("grant_o", 32'(grant_o), (m_pos >= 0) ? (1 << m_owner) : 0);
        check_eq("busy", 32'(busy), 32'((m_pos >= 0) || (m_gap > 0)));
        check_eq("abort_o", 32'(abort_o), 32'(m_abort));
        check_eq("overrun_cnt", 32'(overrun_cnt), m_ovr);
    end

    int n_abort_seen = 0;
    always @(negedge clk) if (abort_o === 1'b1) n_abort_seen++;

    task automatic nc();
        @(negedge clk);
        req = '0;
    endtask

    task automatic strobe(input int s, input int c, input int a);
        req[s]        = 1'b1;
        cmd[8*s +: 8] = 8'(c);
        arg[8*s +: 8] = 8'(a);
    endtask

    // Call right after a negedge; reset spans one rising edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    int exp_b[4];
    int cnt;

    initial begin
        rst      = 1'b1;
        req      = '0;
        cmd      = '0;
        arg      = '0;
        tx_ready = 1'b1;
        repeat (2) nc();
        check_eq("rst_valid", 32'(tx_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_grant", 32'(grant_o), 0);
        check_eq("rst_ovr", 32'(overrun_cnt), 0);
        #2 rst = 1'b0;

        // Single request, latency and gap length
        nc(); strobe(0, 21, 3);
        nc(); check_eq("t1_lat", 32'(tx_valid), 0);
        exp_b = '{50, 21, 0, 3};
        for (int b = 0; b < 4; b++) begin
            nc();
            check_eq("t1_data", 32'(tx_data), exp_b[b]);
            check_eq("t1_last", 32'(tx_last), 32'(b == 3));
        end
        repeat (20) nc(); check_eq("t1_busy_gap", 32'(busy), 1);
        nc();             check_eq("t1_busy_end", 32'(busy), 0);

        // Simultaneous requests, pointer 0
        do_reset();
        nc(); strobe(0, 21, 3); strobe(1, 22, 46);
        nc();
        nc(); check_eq("t2_grant0", 32'(grant_o), 1); check_eq("t2_hdr0", 32'(tx_data), 50);
        repeat (24) nc(); check_eq("t2_gap", 32'(tx_valid), 0);
        nc(); check_eq("t2_grant1", 32'(grant_o), 2); check_eq("t2_hdr1", 32'(tx_data), 50);
        nc(); check_eq("t2_cmd1", 32'(tx_data), 22);
        repeat (2) nc(); check_eq("t2_arg1", 32'(tx_data), 46);
        repeat (25) nc();

        // Backpressure on byte 1
        do_reset();
        nc(); strobe(0, 21, 3);
        repeat (3) nc(); tx_ready = 1'b0;
        repeat (5) nc(); tx_ready = 1'b1;
        check_eq("t3_hold", 32'(tx_data), 21);
        nc(); check_eq("t3_pad", 32'(tx_data), 0);
        nc(); check_eq("t3_arg", 32'(tx_data), 3);
        repeat (25) nc();
        check_eq("t3_noabort", 32'(n_abort_seen), 0);

        // Timeout with overrun saturation on source 1 during the stall
        do_reset();
        nc(); strobe(0, 21, 3); tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            nc(); strobe(1, i, 255 - i);
        end
        repeat (740) nc();
        check_eq("t4_abort_once", 32'(n_abort_seen), 1);
        check_eq("t4_valid_drop", 32'(tx_valid), 0);
        check_eq("t4_ovr_sat", 32'(overrun_cnt), 255);
        tx_ready = 1'b1;
        repeat (60) nc();
        check_eq("t4_idle", 32'(busy), 0);

        // Overrun of source 0 while source 1 owns the link
        do_reset();
        nc(); strobe(1, 22, 46);
        nc();
        nc(); strobe(0, 31, 7); check_eq("t5_owner", 32'(grant_o), 2);
        nc(); strobe(0, 32, 8);
        nc(); strobe(0, 33, 9);
        nc(); check_eq("t5_ovr", 32'(overrun_cnt), 2);
        repeat (22) nc(); check_eq("t5_grant", 32'(grant_o), 1);
        nc(); check_eq("t5_cmd", 32'(tx_data), 33);
        repeat (2) nc(); check_eq("t5_arg", 32'(tx_data), 9);
        repeat (25) nc();

        // Async reset during byte 2
        do_reset();
        nc(); strobe(0, 21, 3);
        repeat (3) nc();
        #2 rst = 1'b1;
        #1;
        check_eq("t6_valid", 32'(tx_valid), 0);
        check_eq("t6_grant", 32'(grant_o), 0);
        check_eq("t6_busy", 32'(busy), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            nc();
            if (tx_valid === 1'b1) cnt++;
        end
        check_eq("t6_no_bytes", 32'(cnt), 0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            nc();
            for (int s = 0; s < NREQ; s++) begin
                if ($urandom_range(7) == 0) strobe(s, int'($urandom_range(255)), int'($urandom_range(255)));
            end
            tx_ready = ($urandom_range(3) != 0);
        end
        tx_ready = 1'b1;
        repeat (120) nc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
